// File: rtl/iob_eth_tb_axi_master.sv
// Bench-side AXI4 burst master: turns one command plus a write or read data
// stream into a single INCR burst, tracking beats, responses and protocol errors.
module iob_eth_tb_axi_master #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_ADDR_W = 24,
    parameter int AXI_DATA_W = 32,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ID     = 0
) (
    input  logic                    clk_i,
    input  logic                    arst_n_i,
    // command interface
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_we_i,
    input  logic [AXI_ADDR_W-1:0]   cmd_addr_i,
    input  logic [AXI_LEN_W-1:0]    cmd_len_i,
    // write stream
    input  logic [AXI_DATA_W-1:0]   wr_data_i,
    input  logic                    wr_valid_i,
    output logic                    wr_ready_o,
    // read stream
    output logic [AXI_DATA_W-1:0]   rd_data_o,
    output logic                    rd_valid_o,
    input  logic                    rd_ready_i,
    output logic                    rd_last_o,
    // status
    output logic                    done_o,
    output logic [1:0]              resp_o,
    output logic                    err_o,
    output logic                    busy_o,
    // AXI write address
    output logic [AXI_ID_W-1:0]     axi_awid_o,
    output logic [AXI_ADDR_W-1:0]   axi_awaddr_o,
    output logic [AXI_LEN_W-1:0]    axi_awlen_o,
    output logic [2:0]              axi_awsize_o,
    output logic [1:0]              axi_awburst_o,
    output logic                    axi_awlock_o,
    output logic [3:0]              axi_awcache_o,
    output logic [2:0]              axi_awprot_o,
    output logic [3:0]              axi_awqos_o,
    output logic                    axi_awvalid_o,
    input  logic                    axi_awready_i,
    // AXI write data
    output logic [AXI_DATA_W-1:0]   axi_wdata_o,
    output logic [AXI_DATA_W/8-1:0] axi_wstrb_o,
    output logic                    axi_wlast_o,
    output logic                    axi_wvalid_o,
    input  logic                    axi_wready_i,
    // AXI write response
    input  logic [AXI_ID_W-1:0]     axi_bid_i,
    input  logic [1:0]              axi_bresp_i,
    input  logic                    axi_bvalid_i,
    output logic                    axi_bready_o,
    // AXI read address
    output logic [AXI_ID_W-1:0]     axi_arid_o,
    output logic [AXI_ADDR_W-1:0]   axi_araddr_o,
    output logic [AXI_LEN_W-1:0]    axi_arlen_o,
    output logic [2:0]              axi_arsize_o,
    output logic [1:0]              axi_arburst_o,
    output logic                    axi_arlock_o,
    output logic [3:0]              axi_arcache_o,
    output logic [2:0]              axi_arprot_o,
    output logic [3:0]              axi_arqos_o,
    output logic                    axi_arvalid_o,
    input  logic                    axi_arready_i,
    // AXI read data
    input  logic [AXI_ID_W-1:0]     axi_rid_i,
    input  logic [AXI_DATA_W-1:0]   axi_rdata_i,
    input  logic [1:0]              axi_rresp_i,
    input  logic                    axi_rlast_i,
    input  logic                    axi_rvalid_i,
    output logic                    axi_rready_o
);
    localparam int                    SIZE      = $clog2(AXI_DATA_W/8);
    localparam logic [AXI_ID_W-1:0]   ID_C      = AXI_ID_W'(AXI_ID);
    localparam logic [AXI_ADDR_W-1:0] ADDR_MASK = ~(AXI_ADDR_W'((1 << SIZE) - 1));

    typedef enum logic [2:0] {IDLE, WADDR, WDATA, WRESP, RADDR, RDATA} state_t;

    state_t                  state_q, state_d;
    logic [AXI_ADDR_W-1:0]   addr_q, addr_d;
    logic [AXI_LEN_W-1:0]    len_q, len_d;
    logic [AXI_LEN_W-1:0]    cnt_q, cnt_d;
    logic [1:0]              resp_q, resp_d;
    logic                    err_q, err_d;
    logic                    done_q, done_d;
    // run_q keeps cmd_ready_o low while reset is held, high from the first clock after release
    logic                    run_q, run_d;
    logic                    last_beat;

    assign last_beat = (cnt_q == len_q);
    assign run_d     = 1'b1;

    // Fixed AXI attributes: full-width INCR bursts, normal access, constant ID
    assign axi_awid_o    = ID_C;
    assign axi_awaddr_o  = addr_q;
    assign axi_awlen_o   = len_q;
    assign axi_awsize_o  = 3'(SIZE);
    assign axi_awburst_o = 2'b01;
    assign axi_awlock_o  = 1'b0;
    assign axi_awcache_o = 4'd0;
    assign axi_awprot_o  = 3'd0;
    assign axi_awqos_o   = 4'd0;
    assign axi_wstrb_o   = '1;
    assign axi_wdata_o   = wr_data_i;
    assign axi_arid_o    = ID_C;
    assign axi_araddr_o  = addr_q;
    assign axi_arlen_o   = len_q;
    assign axi_arsize_o  = 3'(SIZE);
    assign axi_arburst_o = 2'b01;
    assign axi_arlock_o  = 1'b0;
    assign axi_arcache_o = 4'd0;
    assign axi_arprot_o  = 3'd0;
    assign axi_arqos_o   = 4'd0;
    assign rd_data_o     = axi_rdata_i;
    assign done_o        = done_q;
    assign resp_o        = resp_q;
    assign err_o         = err_q;

    // State and command registers; reset drops every bus valid at once
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            resp_q  <= 2'b00;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            resp_q  <= resp_d;
            err_q   <= err_d;
            done_q  <= done_d;
            run_q   <= run_d;
        end
    end

    // Next state, beat counting, response tracking and channel gating
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        resp_d        = resp_q;
        err_d         = err_q;
        done_d        = 1'b0;
        cmd_ready_o   = 1'b0;
        busy_o        = 1'b1;
        axi_awvalid_o = 1'b0;
        axi_arvalid_o = 1'b0;
        axi_wvalid_o  = 1'b0;
        axi_wlast_o   = 1'b0;
        wr_ready_o    = 1'b0;
        axi_bready_o  = 1'b0;
        axi_rready_o  = 1'b0;
        rd_valid_o    = 1'b0;
        rd_last_o     = 1'b0;
        case (state_q)
            IDLE: begin
                cmd_ready_o = run_q;
                busy_o      = 1'b0;
                if (cmd_valid_i && run_q) begin
                    addr_d  = cmd_addr_i & ADDR_MASK;
                    len_d   = cmd_len_i;
                    resp_d  = 2'b00;
                    err_d   = 1'b0;
                    state_d = cmd_we_i ? WADDR : RADDR;
                end
            end
            WADDR: begin
                axi_awvalid_o = 1'b1;
                if (axi_awready_i) begin
                    cnt_d   = '0;
                    state_d = WDATA;
                end
            end
            WDATA: begin
                axi_wvalid_o = wr_valid_i;
                wr_ready_o   = axi_wready_i;
                axi_wlast_o  = last_beat;
                if (wr_valid_i && axi_wready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) state_d = WRESP;
                end
            end
            WRESP: begin
                axi_bready_o = 1'b1;
                if (axi_bvalid_i) begin
                    resp_d  = axi_bresp_i;
                    if (axi_bid_i != ID_C) err_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            RADDR: begin
                axi_arvalid_o = 1'b1;
                if (axi_arready_i) begin
                    cnt_d   = '0;
                    state_d = RDATA;
                end
            end
            RDATA: begin
                rd_valid_o   = axi_rvalid_i;
                axi_rready_o = rd_ready_i;
                rd_last_o    = axi_rlast_i;
                if (axi_rvalid_i && rd_ready_i) begin
                    cnt_d = cnt_q + 1'b1;
                    if (axi_rresp_i > resp_q) resp_d = axi_rresp_i;
                    // early/late rlast or a foreign ID both flag the command
                    if ((axi_rlast_i != last_beat) || (axi_rid_i != ID_C)) err_d = 1'b1;
                    if (last_beat || axi_rlast_i) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: doc/iob_eth_tb_axi_master.md
Name: iob_eth_tb_axi_master

Overview:
- Testbench-side AXI4 burst master for the Ethernet DMA memory simulation environment.
- Turns a simple command/stream interface into correct AXI4 INCR bursts: proper wlast, B-channel handling, rlast checking and response reporting.
- Occupies the testbench slave slot of the system AXI interconnect, alongside the Ethernet DMA, in front of the AXI RAM model.
- Lets benches preload and inspect frame buffers in bursts of 1 to 2^AXI_LEN_W beats.

Parameters:
AXI_ID_W, 1, ID width
AXI_ADDR_W, 24, byte address width
AXI_DATA_W, 32, data width (power of 2, >=8)
AXI_LEN_W, 8, burst length field width
AXI_ID, 0, constant ID driven on awid/arid

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&ready
cmd_we_i  in  1  1=write burst, 0=read burst
cmd_addr_i  in  AXI_ADDR_W  start byte address
cmd_len_i  in  AXI_LEN_W  beats minus 1
wr_data_i  in  AXI_DATA_W  write stream data
wr_valid_i / wr_ready_o  in/out  1  write stream handshake
rd_data_o  out  AXI_DATA_W  read stream data
rd_valid_o / rd_ready_i  out/in  1  read stream handshake
rd_last_o  out  1  last read beat
done_o  out  1  one-cycle completion pulse
resp_o  out  2  worst AXI response of last command
err_o  out  1  protocol error on last command
busy_o  out  1  command in progress
axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}_o, axi_awready_i  out/in  AXI write address channel
axi_w{data,strb,last,valid}_o, axi_wready_i  out/in  AXI write data channel
axi_b{id,resp,valid}_i, axi_bready_o  in/out  AXI write response channel
axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,valid}_o, axi_arready_i  out/in  AXI read address channel
axi_r{id,data,resp,last,valid}_i, axi_rready_o  in/out  AXI read data channel

Behaviour:
- Reset (async assert, sync release): state IDLE, all valid/ready/bready/rready outputs 0; done_o, err_o, busy_o = 0; resp_o = 0; counters 0.
- Reset mid-burst aborts the command: bus valids drop immediately and no done_o is issued.
- Constant fields: awsize/arsize = log2(AXI_DATA_W/8); burst = 2'b01 (INCR); lock/cache/prot/qos = 0; wstrb all ones.
- Address: addr low log2(AXI_DATA_W/8) bits forced to 0; id = AXI_ID.
- FSM states: IDLE, WADDR, WDATA, WRESP, RADDR, RDATA.
- IDLE:
  - cmd_ready_o = 1, busy_o = 0.
  - On cmd_valid_i: latch addr/len/we, clear resp and err, go to WADDR or RADDR.
- WADDR/RADDR:
  - awvalid/arvalid = 1 from the cycle after acceptance; held stable until the ready handshake.
  - On handshake go to WDATA/RDATA. Beat counter cleared.
- WDATA:
  - Combinational pass-through: axi_wvalid_o = wr_valid_i, wr_ready_o = axi_wready_i, axi_wdata_o = wr_data_i.
  - axi_wlast_o = (count == len).
  - Count increments per handshake; last handshake goes to WRESP.
- WRESP:
  - bready = 1; on bvalid latch bresp into resp_o and go to IDLE.
  - done_o pulses in the cycle after the B handshake.
- RDATA:
  - Pass-through: rd_valid_o = axi_rvalid_i, axi_rready_o = rd_ready_i, rd_data_o = axi_rdata_i, rd_last_o = axi_rlast_i.
  - resp_o = max(resp_o, rresp) per beat.
  - Completes on the beat where count == len or rlast, whichever comes first: go to IDLE, done_o next cycle.
  - err_o = 1 if rlast and (count == len) disagree, or rid != AXI_ID.
- Write B-channel: err_o = 1 if bid != AXI_ID.
- busy_o = 1 in all states except IDLE.
- Length 0 (single beat): wlast is asserted on the first beat.
- Max length: counter is AXI_LEN_W bits; len all ones completes at count wrap value without overflow.
- Back-to-back: a new command may be accepted in the same cycle done_o is high (state IDLE).
- resp_o/err_o hold until the next command is accepted.
- No 4KB-boundary splitting: the caller keeps bursts within 4KB.

Test Plan:
- Write 1 beat 0xDEADBEEF at 0x100, then read len=0 at 0x100 -> rd_data_o = 0xDEADBEEF, rd_last_o = 1, resp_o = 0, err_o = 0, done_o pulses once per command.
- Write len=15 at 0x400 with data 0..15, read back -> 16 beats 0..15; wlast only on beat 16; rd_last_o on beat 16.
- Backpressure: random wr_valid_i gaps and rd_ready_i low 50% plus awready held low 5 cycles -> awaddr stable while waiting, data intact, no extra or missing beats.
- Memory model returns rresp = 2 on beat 3 of 8 -> resp_o = 2 after done_o, all 8 beats delivered.
- Model asserts rlast on beat 4 of len=7 read -> completion after 4 beats, err_o = 1.
- arst_n_i low during beat 5 of a 16-beat write -> all valids 0 asynchronously, cmd_ready_o = 1 after release, no done_o pulse.
